// File: rtl/clk_rst_sequencer.sv
// clk_rst_sequencer
// Generates staggered, synchronously released domain resets and their clock
// enables from one raw asynchronous reset. A software re-reset can be
// requested once every domain is running.

`timescale 1ns/1ps

module clk_rst_sequencer #(
  parameter int FANOUT      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int CLKEN_LEAD  = 2,
  parameter int STAGGER     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sw_rst_req,
  output logic [FANOUT-1:0] reset_n_out,
  output logic [FANOUT-1:0] clk_en,
  output logic              rst_done,
  output logic              busy
);

  // Counter must hold the longest dwell of any phase; one spare bit of
  // headroom keeps the saturating increment away from the compare values.
  localparam int MAX_A   = (HOLD_CYCLES > CLKEN_LEAD) ? HOLD_CYCLES : CLKEN_LEAD;
  localparam int MAX_B   = STAGGER * FANOUT;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [2:0] ST_ASSERT  = 3'd0;
  localparam logic [2:0] ST_HOLD    = 3'd1;
  localparam logic [2:0] ST_CLKEN   = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_RUN     = 3'd4;

  // Reject nonsensical configurations while elaborating.
  if (FANOUT < 1) begin : g_bad_fanout
    $error("clk_rst_sequencer: FANOUT must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("clk_rst_sequencer: SYNC_STAGES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("clk_rst_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (CLKEN_LEAD < 1) begin : g_bad_lead
    $error("clk_rst_sequencer: CLKEN_LEAD must be >= 1");
  end
  if (STAGGER < 1) begin : g_bad_stagger
    $error("clk_rst_sequencer: STAGGER must be >= 1");
  end

  // The state register itself acts as the final synchronizer stage: the FSM
  // samples the second-to-last stage, so ASSERT is left on exactly the edge
  // on which a SYNC_STAGES-deep chain would report release.
  logic [SYNC_STAGES-2:0] sync_q;
  logic                   sync_release;

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nx;
  logic [CW-1:0]     cnt_inc;
  logic [FANOUT-1:0] rn_nx;
  logic [FANOUT-1:0] en_nx;
  logic [FANOUT-1:0] rn_first;
  logic [FANOUT-1:0] rn_shift;
  logic              done_nx;
  logic              busy_nx;
  logic              hold_done;
  logic              lead_done;
  logic              stagger_done;

  assign sync_release = ~sync_q[SYNC_STAGES-2];

  // Saturating increment so a stuck phase can never wrap back into a match.
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);

  assign hold_done    = (cnt == CW'(HOLD_CYCLES - 1));
  assign lead_done    = (cnt == CW'(CLKEN_LEAD - 1));
  assign stagger_done = (cnt == CW'(STAGGER - 1));

  // Domains release in ascending order by shifting ones in from bit 0.
  assign rn_first = FANOUT'(1);
  assign rn_shift = (reset_n_out << 1) | FANOUT'(1);

  // Release synchronizer: set by the raw reset, drains to zero afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_q << 1;
    end
  end

  // Next-state and next-output decode for the sequencing FSM.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rn_nx    = reset_n_out;
    en_nx    = clk_en;
    case (state)
      ST_ASSERT: begin
        rn_nx  = '0;
        en_nx  = '0;
        cnt_nx = '0;
        if (sync_release) begin
          state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        rn_nx = '0;
        en_nx = '0;
        if (hold_done) begin
          state_nx = ST_CLKEN;
          cnt_nx   = '0;
          en_nx    = '1;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      ST_CLKEN: begin
        rn_nx = '0;
        en_nx = '1;
        if (lead_done) begin
          cnt_nx = '0;
          rn_nx  = rn_first;
          if (&rn_first) begin
            state_nx = ST_RUN;
          end else begin
            state_nx = ST_RELEASE;
          end
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      ST_RELEASE: begin
        en_nx = '1;
        if (stagger_done) begin
          cnt_nx = '0;
          rn_nx  = rn_shift;
          if (&rn_shift) begin
            state_nx = ST_RUN;
          end
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      ST_RUN: begin
        rn_nx = '1;
        en_nx = '1;
        if (sw_rst_req) begin
          state_nx = ST_HOLD;
          cnt_nx   = '0;
          rn_nx    = '0;
          en_nx    = '0;
        end
      end
      default: begin
        state_nx = ST_ASSERT;
        cnt_nx   = '0;
        rn_nx    = '0;
        en_nx    = '0;
      end
    endcase
    done_nx = (state_nx == ST_RUN);
    busy_nx = ~done_nx;
  end

  // State, counter and every output are registered; raw reset clears them at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_ASSERT;
      cnt         <= '0;
      reset_n_out <= '0;
      clk_en      <= '0;
      rst_done    <= 1'b0;
      busy        <= 1'b1;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      reset_n_out <= rn_nx;
      clk_en      <= en_nx;
      rst_done    <= done_nx;
      busy        <= busy_nx;
    end
  end

endmodule
